// File: rtl/seq_scan_pkg.sv
// ---------------------------------------------------------------------------
// seq_scan_pkg
// Shared types and helpers for the serial run-of-ones scan controller.
//   state_t   : controller FSM encoding (IDLE=0, SHIFT=1, DONE=2)
//   width_for : number of bits needed to hold the values 0..max_value
// ---------------------------------------------------------------------------
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits required to represent every value in 0..max_value (at least 1).
    function automatic int width_for(input int max_value);
        int w;
        w = 1;
        while ((1 << w) <= max_value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_scan_if.sv
// ---------------------------------------------------------------------------
// seq_scan_if
// Bundle of the word handshake, serial observation and result signals of
// seq_scan_ctrl.
//   master : word producer / status consumer side (drives in_valid, in_data,
//            abort; observes everything else)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface seq_scan_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              abort;
    logic              ser_x;
    logic              ser_vld;
    logic              z;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  first_idx;
    logic              first_vld;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, ser_x, ser_vld, z, busy, done,
               match_cnt, first_idx, first_vld
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, ser_x, ser_vld, z, busy, done,
               match_cnt, first_idx, first_vld
    );
endinterface

// File: rtl/seq_scan_run_detector.sv
// ---------------------------------------------------------------------------
// run_detector
// Mealy detector for RUN_LEN consecutive 1s on a serial bit stream.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear the run counter (start of a new word)
//   en       : x carries a valid bit this cycle
//   x        : serial input bit
//   z        : combinational hit for the current bit
// The run counter saturates at RUN_LEN so long runs keep hitting on every
// further 1 without wrapping.
// ---------------------------------------------------------------------------
module run_detector
    import seq_scan_pkg::*;
#(
    parameter int RUN_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    localparam int RUN_W = width_for(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    logic [RUN_W-1:0] run_reg;
    logic             run_long;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_reg <= '0;
        end else if (clr) begin
            run_reg <= '0;
        end else if (en) begin
            if (!x) begin
                run_reg <= '0;
            end else if (run_reg != RUN_MAX) begin
                run_reg <= run_reg + RUN_W'(1);
            end
        end
    end

    // With RUN_LEN=1 every 1 is a hit, so no prior run is required.
    generate
        if (RUN_LEN == 1) begin : g_single
            assign run_long = 1'b1;
        end else begin : g_multi
            assign run_long = (run_reg >= RUN_W'(RUN_LEN - 1));
        end
    endgenerate

    assign z = en & x & run_long;

endmodule

// File: rtl/seq_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seq_scan_ctrl
// Accepts one DATA_W-bit word per valid/ready handshake, shifts it MSB-first
// one bit per cycle through a run-of-ones detector, and reports the number
// of hits plus the bit index (0 = MSB) of the first hit when the word ends.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.slave  : in_valid/in_ready/in_data handshake, abort,
//                ser_x/ser_vld/z serial view, busy/done status,
//                match_cnt/first_idx/first_vld results
// Timing: accept at cycle T, bits on T+1..T+DATA_W, done pulse at
// T+DATA_W+1, next accept possible at T+DATA_W+2.
// ---------------------------------------------------------------------------
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_scan_if.slave  bus
);

    localparam int IDX_W = width_for(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] shreg_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  match_cnt_reg;
    logic [CNT_W-1:0]  first_idx_reg;
    logic              first_vld_reg;

    logic accept;
    logic shift_en;
    logic abort_scan;
    logic ser_bit;
    logic det_z;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        bus.in_ready = 1'b0;
        shift_en     = 1'b0;
        abort_scan   = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state_reg)
            IDLE: begin
                // abort blocks acceptance even when a word is offered
                bus.in_ready = !bus.abort;
                if (bus.in_valid && !bus.abort) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                bus.busy = 1'b1;
                if (bus.abort) begin
                    abort_scan = 1'b1;
                    state_next = IDLE;
                end else if (idx_reg == IDX_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // abort is deliberately ignored here: the word already finished
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- serial datapath ----------------
    assign ser_bit     = shift_en & shreg_reg[DATA_W-1];
    assign bus.ser_x   = ser_bit;
    assign bus.ser_vld = shift_en;
    assign bus.z       = det_z;

    run_detector #(
        .RUN_LEN (RUN_LEN)
    ) u_det (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (shift_en),
        .x   (ser_bit),
        .z   (det_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg     <= '0;
            idx_reg       <= '0;
            match_cnt_reg <= '0;
            first_idx_reg <= '0;
            first_vld_reg <= 1'b0;
        end else if (accept) begin
            shreg_reg     <= bus.in_data;
            idx_reg       <= '0;
            match_cnt_reg <= '0;
            first_idx_reg <= '0;
            first_vld_reg <= 1'b0;
        end else if (abort_scan) begin
            idx_reg       <= '0;
            match_cnt_reg <= '0;
            first_idx_reg <= '0;
            first_vld_reg <= 1'b0;
        end else if (shift_en) begin
            shreg_reg <= {shreg_reg[DATA_W-2:0], 1'b0};
            idx_reg   <= idx_reg + IDX_W'(1);
            if (det_z) begin
                if (match_cnt_reg != {CNT_W{1'b1}}) begin
                    match_cnt_reg <= match_cnt_reg + CNT_W'(1);
                end
                if (!first_vld_reg) begin
                    first_idx_reg <= CNT_W'(idx_reg);
                    first_vld_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.match_cnt = match_cnt_reg;
    assign bus.first_idx = first_idx_reg;
    assign bus.first_vld = first_vld_reg;

endmodule
